// File: rtl/uart_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_loader_pkg;

    // Frame-level states of the loader.
    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        CSUM,
        DRAIN,
        DONE,
        ERR
    } loader_state_t;

    // 10 ms of silence at 50 MHz.
    localparam int UART_LOADER_TIMEOUT_DEFAULT = 500_000;

    // Number of UART bytes that make up one word.
    function automatic int loader_bytes(input int word_w);
        return word_w / 8;
    endfunction

endpackage

// File: rtl/uart_loader_if.sv
// Memory write handshake between the loader and the memory controller.
interface uart_loader_if #(
    parameter int ADDR_W = 25,
    parameter int WORD_W = 16
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              wr_ack;

    // Loader side issues writes, memory side acknowledges them.
    modport master (output wr_en, output wr_addr, output wr_data, input wr_ack);
    modport slave  (input wr_en, input wr_addr, input wr_data, output wr_ack);
endinterface

// File: rtl/uart_loader_fifo.sv
// Small synchronous word FIFO with registered read data and synchronous flush.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr;
    logic [PTR_W:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);

    // Pointer bookkeeping; flush empties the FIFO in one cycle.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (PTR_W+1)'(1);
        end
    end

    // Storage array write port.
    // NOTE: the storage array has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PTR_W-1:0]] <= push_data;
    end

    // Registered read port, loaded only on a pop (no bypass from the write side).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pop_data <= '0;
        end else if (do_pop) begin
            pop_data <= mem[rd_ptr[PTR_W-1:0]];
        end
    end

endmodule

// File: rtl/uart_loader.sv
// Streaming program loader: assembles UART bytes into words, parses a
// length/payload/checksum frame and writes the payload to memory through a
// one-outstanding-write handshake.
module uart_loader
    import uart_loader_pkg::*;
#(
    parameter int                WORD_W      = 16,
    parameter int                ADDR_W      = 25,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter bit                MSB_FIRST   = 1'b1,
    parameter int                FIFO_DEPTH  = 4,
    parameter int                TIMEOUT_CYC = UART_LOADER_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              byte_valid,
    input  logic [7:0]        rx_byte,
    uart_loader_if.master     mem,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] word_count
);
    localparam int BYTES = loader_bytes(WORD_W);
    localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

    loader_state_t     state;
    logic              en_q;
    logic              start_pend;
    logic              start;
    logic              active;
    logic              byte_take;
    logic              timeout;

    logic [IDX_W-1:0]  byte_idx;
    logic [WORD_W-1:0] shift_q;
    logic [WORD_W-1:0] word_q;
    logic [WORD_W-1:0] word_next;
    logic [WORD_W+7:0] word_cat;
    logic              word_valid;

    logic [ADDR_W-1:0] len_q;
    logic [ADDR_W-1:0] rx_count;
    logic [WORD_W-1:0] sum_q;
    logic [TO_W-1:0]   tcnt;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic              overflow;
    logic [WORD_W-1:0] fifo_data;

    assign active    = state inside {LEN, DATA, CSUM};
    // Bytes arriving while en is low (including the cycle it falls) are dropped.
    assign byte_take = byte_valid && en && active;
    assign timeout   = active && !byte_valid && (tcnt == TO_W'(TIMEOUT_CYC - 1));
    // A session starts on an en rise, deferred until an aborted write has been acknowledged.
    assign start     = (state == IDLE) && en && (start_pend || !en_q) && !mem.wr_en;
    assign fifo_push = word_valid && en && (state == DATA);
    assign fifo_pop  = en && !fifo_empty && !mem.wr_en;
    assign overflow  = fifo_push && fifo_full && !fifo_pop;
    assign busy      = (state inside {LEN, DATA, CSUM, DRAIN}) || mem.wr_en;
    assign mem.wr_data = fifo_data;

    // Merge the incoming byte into the partial word in the configured byte order.
    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        word_cat  = '0;
        word_next = '0;
        if (MSB_FIRST) begin
            word_cat  = {shift_q, rx_byte};
            word_next = word_cat[WORD_W-1:0];
        end else begin
            word_cat  = {rx_byte, shift_q};
            word_next = word_cat[WORD_W+7:8];
        end
    end

    // Byte assembler: the completed word is presented to the FSM one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_idx   <= '0;
            shift_q    <= '0;
            word_q     <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= 1'b0;
            if (!en || timeout || !active) begin
                byte_idx <= '0;
            end else if (byte_take) begin
                shift_q <= word_next;
                if (byte_idx == IDX_W'(BYTES - 1)) begin
                    byte_idx   <= '0;
                    word_q     <= word_next;
                    word_valid <= 1'b1;
                end else begin
                    byte_idx <= byte_idx + IDX_W'(1);
                end
            end
        end
    end

    // Frame FSM with registered done/err, timeout counter and running checksum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            en_q       <= 1'b0;
            start_pend <= 1'b0;
            len_q      <= '0;
            rx_count   <= '0;
            sum_q      <= '0;
            tcnt       <= '0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            en_q       <= en;
            start_pend <= en && (start_pend || !en_q) && !start;
            if (!en) begin
                state <= IDLE;
                done  <= 1'b0;
                err   <= 1'b0;
                tcnt  <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            state    <= LEN;
                            len_q    <= '0;
                            rx_count <= '0;
                            sum_q    <= '0;
                            tcnt     <= '0;
                            done     <= 1'b0;
                            err      <= 1'b0;
                        end
                    end
                    LEN, DATA, CSUM: begin
                        if (timeout) begin
                            state <= ERR;
                            err   <= 1'b1;
                        end else begin
                            tcnt <= byte_valid ? '0 : tcnt + TO_W'(1);
                            if (word_valid) begin
                                if (state == LEN) begin
                                    len_q <= ADDR_W'(word_q);
                                    state <= (word_q == '0) ? CSUM : DATA;
                                end else if (state == DATA) begin
                                    if (overflow) begin
                                        state <= ERR;
                                        err   <= 1'b1;
                                    end else begin
                                        sum_q    <= sum_q + word_q;
                                        rx_count <= rx_count + ADDR_W'(1);
                                        if (rx_count + ADDR_W'(1) == len_q) state <= CSUM;
                                    end
                                end else begin
                                    if (word_q == sum_q) begin
                                        state <= DRAIN;
                                    end else begin
                                        state <= ERR;
                                        err   <= 1'b1;
                                    end
                                end
                            end
                        end
                    end
                    DRAIN: begin
                        if (fifo_empty && !mem.wr_en) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end
                    DONE, ERR: ;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // Writer: one outstanding write, held stable until acknowledged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem.wr_en   <= 1'b0;
            mem.wr_addr <= '0;
            word_count  <= '0;
        end else if (mem.wr_en) begin
            if (mem.wr_ack) begin
                mem.wr_en  <= 1'b0;
                word_count <= word_count + ADDR_W'(1);
            end
        end else begin
            if (start) word_count <= '0;
            if (fifo_pop) begin
                mem.wr_en   <= 1'b1;
                mem.wr_addr <= BASE_ADDR + word_count;
            end
        end
    end

    // Payload word buffer between the assembler and the writer.
    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (!en),
        .push      (fifo_push),
        .push_data (word_q),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_uart_loader.sv
// Directed bench for uart_loader: three instances cover MSB-first with a short
// timeout, LSB-first, and a base address at the top of the address space.
module tb_uart_loader;

    localparam int W_DONE  = 0;
    localparam int W_ERR   = 1;
    localparam int W_WE_HI = 2;
    localparam int W_WE_LO = 3;

    typedef struct {
        int          d;
        logic [24:0] a;
        logic [15:0] w;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en_v  [3] = '{default: 1'b0};
    logic       bv_v  [3] = '{default: 1'b0};
    logic [7:0] rb_v  [3] = '{default: 8'h00};
    logic       ack_v [3] = '{default: 1'b0};

    wire        we_w   [3];
    wire [24:0] addr_w [3];
    wire [15:0] data_w [3];
    wire        busy_w [3];
    wire        done_w [3];
    wire        err_w  [3];
    wire [24:0] wc_w   [3];

    int          checks = 0;
    int          errors = 0;
    int          delay_v [3] = '{default: 0};
    bit          hold_v  [3] = '{default: 1'b0};
    int          wcnt    [3] = '{default: 0};
    int          torn = 0;
    logic        prev_en   [3] = '{default: 1'b0};
    logic        prev_ack  [3] = '{default: 1'b0};
    logic [24:0] prev_addr [3];
    logic [15:0] prev_data [3];
    wr_t         wlog [$];
    wr_t         log_e;
    logic [7:0]  txq [$];

    always #5 clk = ~clk;

    uart_loader_if #(.ADDR_W(25), .WORD_W(16)) bus0 ();
    uart_loader_if #(.ADDR_W(25), .WORD_W(16)) bus1 ();
    uart_loader_if #(.ADDR_W(25), .WORD_W(16)) bus2 ();

    assign bus0.wr_ack = ack_v[0];
    assign bus1.wr_ack = ack_v[1];
    assign bus2.wr_ack = ack_v[2];
    assign we_w[0] = bus0.wr_en;  assign addr_w[0] = bus0.wr_addr;  assign data_w[0] = bus0.wr_data;
    assign we_w[1] = bus1.wr_en;  assign addr_w[1] = bus1.wr_addr;  assign data_w[1] = bus1.wr_data;
    assign we_w[2] = bus2.wr_en;  assign addr_w[2] = bus2.wr_addr;  assign data_w[2] = bus2.wr_data;

    uart_loader #(.WORD_W(16), .ADDR_W(25), .BASE_ADDR(25'd0), .MSB_FIRST(1'b1),
                  .FIFO_DEPTH(4), .TIMEOUT_CYC(100)) dut_a (
        .clk(clk), .rst(rst), .en(en_v[0]), .byte_valid(bv_v[0]), .rx_byte(rb_v[0]),
        .mem(bus0), .busy(busy_w[0]), .done(done_w[0]), .err(err_w[0]), .word_count(wc_w[0]));

    uart_loader #(.WORD_W(16), .ADDR_W(25), .BASE_ADDR(25'd0), .MSB_FIRST(1'b0),
                  .FIFO_DEPTH(4), .TIMEOUT_CYC(500_000)) dut_b (
        .clk(clk), .rst(rst), .en(en_v[1]), .byte_valid(bv_v[1]), .rx_byte(rb_v[1]),
        .mem(bus1), .busy(busy_w[1]), .done(done_w[1]), .err(err_w[1]), .word_count(wc_w[1]));

    uart_loader #(.WORD_W(16), .ADDR_W(25), .BASE_ADDR(25'h1FF_FFFF), .MSB_FIRST(1'b1),
                  .FIFO_DEPTH(4), .TIMEOUT_CYC(500_000)) dut_c (
        .clk(clk), .rst(rst), .en(en_v[2]), .byte_valid(bv_v[2]), .rx_byte(rb_v[2]),
        .mem(bus2), .busy(busy_w[2]), .done(done_w[2]), .err(err_w[2]), .word_count(wc_w[2]));

    // Memory model: acknowledge after delay_v cycles unless held off.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++)
            ack_v[d] = we_w[d] && !hold_v[d] && (wcnt[d] >= delay_v[d]);
    end

    // Log accepted writes and flag any request that changes or drops before its ack.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                if (prev_en[d] && !prev_ack[d] &&
                    (!we_w[d] || addr_w[d] !== prev_addr[d] || data_w[d] !== prev_data[d]))
                    torn++;
                if (we_w[d] && ack_v[d]) begin
                    log_e.d = d;
                    log_e.a = addr_w[d];
                    log_e.w = data_w[d];
                    wlog.push_back(log_e);
                    wcnt[d] = 0;
                end else if (we_w[d]) begin
                    wcnt[d]++;
                end else begin
                    wcnt[d] = 0;
                end
                prev_en[d]   = we_w[d];
                prev_ack[d]  = ack_v[d];
                prev_addr[d] = addr_w[d];
                prev_data[d] = data_w[d];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic bit cond(input int d, input int what);
        case (what)
            W_DONE:  return done_w[d];
            W_ERR:   return err_w[d];
            W_WE_HI: return we_w[d];
            W_WE_LO: return !we_w[d];
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int d, input int what, input int budget, input string tag);
        bit met;
        met = 1'b0;
        for (int i = 0; i < budget && !met; i++) begin
            @(negedge clk);
            met = cond(d, what);
        end
        check(tag, 32'(met), 32'd1);
    endtask

    task automatic put_word(input logic [15:0] w, input bit msb);
        if (msb) begin
            txq.push_back(w[15:8]);
            txq.push_back(w[7:0]);
        end else begin
            txq.push_back(w[7:0]);
            txq.push_back(w[15:8]);
        end
    endtask

    // Drain txq to one DUT; gap 0 means back-to-back bytes.
    task automatic send_seq(input int d, input int gap);
        while (txq.size() > 0) begin
            @(negedge clk);
            rb_v[d] = txq.pop_front();
            bv_v[d] = 1'b1;
            if (gap > 0) begin
                @(negedge clk);
                bv_v[d] = 1'b0;
                repeat (gap - 1) @(negedge clk);
            end
        end
        @(negedge clk);
        bv_v[d] = 1'b0;
    endtask

    task automatic start_session(input int d);
        @(negedge clk);
        en_v[d] = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic end_session(input int d, input string tag);
        @(negedge clk);
        en_v[d] = 1'b0;
        wait_for(d, W_WE_LO, 300, tag);
        repeat (3) @(negedge clk);
        wlog.delete();
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            check($sformatf("rst_wr_en%0d", d), 32'(we_w[d]), 32'd0);
            check($sformatf("rst_addr%0d", d), 32'(addr_w[d]), 32'd0);
            check($sformatf("rst_data%0d", d), 32'(data_w[d]), 32'd0);
            check($sformatf("rst_flags%0d", d), {29'd0, busy_w[d], done_w[d], err_w[d]}, 32'd0);
            check($sformatf("rst_wc%0d", d), 32'(wc_w[d]), 32'd0);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // 1: MSB-first frame N=2, payload 1234 ABCD, checksum BE01.
        start_session(0);
        put_word(16'h0002, 1'b1); put_word(16'h1234, 1'b1);
        put_word(16'hABCD, 1'b1); put_word(16'hBE01, 1'b1);
        send_seq(0, 3);
        wait_for(0, W_DONE, 50, "t1_done_seen");
        check("t1_err", 32'(err_w[0]), 32'd0);
        check("t1_wc", 32'(wc_w[0]), 32'd2);
        check("t1_nwr", wlog.size(), 32'd2);
        check("t1_a0", 32'(wlog[0].a), 32'h0);
        check("t1_w0", 32'(wlog[0].w), 32'h1234);
        check("t1_a1", 32'(wlog[1].a), 32'h1);
        check("t1_w1", 32'(wlog[1].w), 32'hABCD);
        check("t1_busy", 32'(busy_w[0]), 32'd0);
        end_session(0, "t1_end");
        check("t1_done_clr", 32'(done_w[0]), 32'd0);

        // 2: LSB-first same payload, then a bad checksum.
        start_session(1);
        put_word(16'h0002, 1'b0); put_word(16'h1234, 1'b0);
        put_word(16'hABCD, 1'b0); put_word(16'hBE01, 1'b0);
        send_seq(1, 3);
        wait_for(1, W_DONE, 50, "t2_done_seen");
        check("t2_nwr", wlog.size(), 32'd2);
        check("t2_w0", {wlog[0].a[15:0], wlog[0].w}, 32'h0000_1234);
        check("t2_w1", {wlog[1].a[15:0], wlog[1].w}, 32'h0001_ABCD);
        end_session(1, "t2_end");
        start_session(1);
        put_word(16'h0002, 1'b0); put_word(16'h1234, 1'b0);
        put_word(16'hABCD, 1'b0); put_word(16'hBE00, 1'b0);
        send_seq(1, 3);
        wait_for(1, W_ERR, 50, "t2b_err_seen");
        check("t2b_done", 32'(done_w[1]), 32'd0);
        check("t2b_nwr", wlog.size(), 32'd2);
        check("t2b_wc", 32'(wc_w[1]), 32'd2);
        end_session(1, "t2b_end");

        // 3: ack held off, six words back-to-back overflow the FIFO.
        hold_v[0] = 1'b1;
        start_session(0);
        put_word(16'h0006, 1'b1);
        for (int i = 1; i <= 6; i++) put_word(16'h1000 + 16'(i), 1'b1);
        send_seq(0, 0);
        wait_for(0, W_ERR, 40, "t3_err_seen");
        check("t3_we_held", 32'(we_w[0]), 32'd1);
        check("t3_nwr_held", wlog.size(), 32'd0);
        repeat (180) @(negedge clk);
        hold_v[0] = 1'b0;
        repeat (40) @(negedge clk);
        check("t3_nwr", wlog.size(), 32'd5);
        check("t3_last", {wlog[4].a[15:0], wlog[4].w}, 32'h0004_1005);
        check("t3_wc", 32'(wc_w[0]), 32'd5);
        check("t3_err_hold", 32'(err_w[0]), 32'd1);
        end_session(0, "t3_end");

        // 4: timeout 100 cycles after the last byte, partial word discarded.
        start_session(0);
        put_word(16'h0003, 1'b1);
        send_seq(0, 2);
        @(negedge clk);
        rb_v[0] = 8'h12;
        bv_v[0] = 1'b1;
        @(negedge clk);
        bv_v[0] = 1'b0;
        repeat (99) @(negedge clk);
        check("t4_err_99", 32'(err_w[0]), 32'd0);
        @(negedge clk);
        check("t4_err_100", 32'(err_w[0]), 32'd1);
        check("t4_no_we", 32'(we_w[0]), 32'd0);
        check("t4_nwr", wlog.size(), 32'd0);
        end_session(0, "t4_end");

        // 5: abort while a write waits 5 cycles for its ack, then a fresh N=1 session.
        delay_v[0] = 5;
        start_session(0);
        put_word(16'h0002, 1'b1); put_word(16'h1111, 1'b1);
        send_seq(0, 2);
        wait_for(0, W_WE_HI, 20, "t5_we_seen");
        en_v[0] = 1'b0;
        @(negedge clk);
        check("t5_we_held", 32'(we_w[0]), 32'd1);
        check("t5_busy_held", 32'(busy_w[0]), 32'd1);
        wait_for(0, W_WE_LO, 20, "t5_we_drop");
        @(negedge clk);
        check("t5_busy_idle", 32'(busy_w[0]), 32'd0);
        check("t5_flags", {30'd0, done_w[0], err_w[0]}, 32'd0);
        check("t5_nwr", wlog.size(), 32'd1);
        check("t5_torn_w", 32'(wlog[0].w), 32'h1111);
        wlog.delete();
        delay_v[0] = 0;
        start_session(0);
        put_word(16'h0001, 1'b1); put_word(16'h5A5A, 1'b1); put_word(16'h5A5A, 1'b1);
        send_seq(0, 3);
        wait_for(0, W_DONE, 50, "t5b_done_seen");
        check("t5b_nwr", wlog.size(), 32'd1);
        check("t5b_wr", {wlog[0].a[15:0], wlog[0].w}, 32'h0000_5A5A);
        check("t5b_wc", 32'(wc_w[0]), 32'd1);
        end_session(0, "t5b_end");

        // 6: address wrap from the top of the address space.
        start_session(2);
        put_word(16'h0002, 1'b1); put_word(16'h0001, 1'b1);
        put_word(16'h0002, 1'b1); put_word(16'h0003, 1'b1);
        send_seq(2, 3);
        wait_for(2, W_DONE, 50, "t6_done_seen");
        check("t6_nwr", wlog.size(), 32'd2);
        check("t6_a0", 32'(wlog[0].a), 32'h1FF_FFFF);
        check("t6_a1", 32'(wlog[1].a), 32'h0);
        check("t6_w1", 32'(wlog[1].w), 32'h0002);
        end_session(2, "t6_end");

        check("no_torn_writes", torn, 0);

        // 7: asynchronous reset in the middle of an outstanding write.
        hold_v[2] = 1'b1;
        start_session(2);
        put_word(16'h0001, 1'b1); put_word(16'h7777, 1'b1);
        send_seq(2, 2);
        wait_for(2, W_WE_HI, 20, "t7_we_seen");
        #2;
        rst = 1'b0;
        #1;
        check("t7_we_async", 32'(we_w[2]), 32'd0);
        check("t7_busy_async", 32'(busy_w[2]), 32'd0);
        check("t7_addr_async", 32'(addr_w[2]), 32'd0);
        en_v[2] = 1'b0;
        hold_v[2] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
